o_gate_mac_seq: RTL and testbench

- Sequencer and multiply-accumulate engine for the LSTM output-gate pre-activation.
- Drives the 8-bit row address of the output-gate weight ROM, which returns one row of UNITS_NUM packed D_WL-bit weights combinationally in the same cycle.
- Multiplies each row by one streamed input/hidden element and accumulates over VEC_LEN rows, plus a per-unit bias.
- Emits UNITS_NUM saturated D_WL-bit sums to the gate activation stage through a valid/ready handshake.

---
 rtl/o_gate_mac_seq.sv | 136 +++++++++++++
 tb/tb_o_gate_mac_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/o_gate_mac_seq.sv
// LSTM output-gate pre-activation: walks the weight ROM row by row, multiplies each
// row by one streamed element, accumulates per lane on top of a bias, emits saturated sums.
module o_gate_mac_seq #(
  parameter int D_WL      = 24,
  parameter int FRAC_BITS = 16,
  parameter int UNITS_NUM = 5,
  parameter int VEC_LEN   = 156,
  parameter int ACC_W     = 34
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [UNITS_NUM*D_WL-1:0] bias,
  input  logic                      x_valid,
  input  logic [D_WL-1:0]           x_data,
  output logic                      x_ready,
  output logic [7:0]                addr,
  input  logic [UNITS_NUM*D_WL-1:0] w_o,
  output logic                      out_valid,
  output logic [UNITS_NUM*D_WL-1:0] out_data,
  input  logic                      out_ready,
  output logic                      busy,
  output logic [1:0]                state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and out_data holds while out_valid is high and unaccepted.

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [7:0] LAST_ADDR = 8'(VEC_LEN - 1);

  logic [1:0]                state_q, state_d;
  logic [7:0]                addr_q, addr_d;
  logic signed [ACC_W-1:0]   acc_q [UNITS_NUM];
  logic signed [ACC_W-1:0]   acc_d [UNITS_NUM];
  logic [UNITS_NUM*D_WL-1:0] out_data_q, out_data_d;

  logic signed [ACC_W-1:0]   bias_ext [UNITS_NUM];
  logic signed [ACC_W-1:0]   acc_sum  [UNITS_NUM];

  function automatic logic [D_WL-1:0] sat_lane(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-D_WL:0] top;
    top = v[ACC_W-1:D_WL-1];
    if ((top == '0) || (top == '1)) begin
      sat_lane = v[D_WL-1:0];
    end else if (v[ACC_W-1]) begin
      sat_lane = {1'b1, {(D_WL-1){1'b0}}};
    end else begin
      sat_lane = {1'b0, {(D_WL-1){1'b1}}};
    end
  endfunction

  for (genvar k = 0; k < UNITS_NUM; k++) begin : g_lane
    logic signed [D_WL-1:0]   w_lane;
    logic signed [D_WL-1:0]   b_lane;
    logic signed [2*D_WL-1:0] prod;

    assign w_lane = w_o[k*D_WL +: D_WL];
    assign b_lane = bias[k*D_WL +: D_WL];
    assign prod   = $signed(x_data) * w_lane;
    // Arithmetic shift floors toward -inf; the shifted product always fits ACC_W.
    assign acc_sum[k]  = acc_q[k] + ACC_W'(prod >>> FRAC_BITS);
    assign bias_ext[k] = ACC_W'(b_lane);
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    out_data_d = out_data_q;
    for (int k = 0; k < UNITS_NUM; k++) begin
      acc_d[k] = acc_q[k];
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int k = 0; k < UNITS_NUM; k++) begin
            acc_d[k] = bias_ext[k];
          end
          addr_d  = '0;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        if (x_valid) begin
          for (int k = 0; k < UNITS_NUM; k++) begin
            acc_d[k] = acc_sum[k];
          end
          if (addr_q == LAST_ADDR) begin
            addr_d  = '0;
            state_d = S_DONE;
            // Result is captured from the final sums so it is valid on the first DONE cycle.
            for (int k = 0; k < UNITS_NUM; k++) begin
              out_data_d[k*D_WL +: D_WL] = sat_lane(acc_sum[k]);
            end
          end else begin
            addr_d = addr_q + 8'd1;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      out_data_q <= '0;
      for (int k = 0; k < UNITS_NUM; k++) begin
        acc_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      out_data_q <= out_data_d;
      for (int k = 0; k < UNITS_NUM; k++) begin
        acc_q[k] <= acc_d[k];
      end
    end
  end

  assign addr      = addr_q;
  assign x_ready   = (state_q == S_ACC);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = out_data_q;
  assign busy      = (state_q != S_IDLE);
  assign state_o   = state_q;

endmodule

// File: tb/tb_o_gate_mac_seq.sv
// Bench for o_gate_mac_seq: ROM stub driven from a per-job weight table, job-level
// reference model of the accumulation, cycle-by-cycle output compare.
module tb_o_gate_mac_seq;
  localparam int DW = 24;
  localparam int UN = 5;
  localparam int VL = 156;
  localparam int PW = UN * DW;

  logic          clk = 1'b0;
  logic          rst_n, start, x_valid, out_ready;
  logic [PW-1:0] bias, w_o, out_data;
  logic [DW-1:0] x_data;
  logic          x_ready, out_valid, busy;
  logic [7:0]    addr;
  logic [1:0]    state_dbg;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  o_gate_mac_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
    .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready), .addr(addr),
    .w_o(w_o), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .state_o(state_dbg)
  );

  // Weight ROM stub and per-beat input values for the current job
  logic [DW-1:0] w_tab [VL][UN];
  logic [DW-1:0] x_tab [VL];

  always_comb begin
    w_o = '0;
    for (int k = 0; k < UN; k++) begin
      if (int'(addr) < VL) w_o[k*DW +: DW] = w_tab[int'(addr)][k];
    end
  end

  function automatic longint lane_of(input logic [PW-1:0] v, input int k);
    logic signed [DW-1:0] s;
    s = v[k*DW +: DW];
    return longint'(s);
  endfunction

  function automatic longint fx_mul(input logic [DW-1:0] x, input logic [DW-1:0] w);
    logic signed [DW-1:0] xs, ws;
    xs = x;
    ws = w;
    return (longint'(xs) * longint'(ws)) >>> 16;
  endfunction

  function automatic logic [DW-1:0] sat24(input longint v);
    if (v > 64'sd8388607) return 24'h7FFFFF;
    if (v < -64'sd8388608) return 24'h800000;
    return v[DW-1:0];
  endfunction

  // Reference model: phase 0 idle, 1 accumulating, 2 holding a result
  int            m_phase;
  int            m_beats;
  longint        m_acc [UN];
  logic [PW-1:0] m_out;
  bit            m_data_zero;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase     <= 0;
      m_beats     <= 0;
      m_data_zero <= 1'b1;
      for (int k = 0; k < UN; k++) m_acc[k] <= 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase <= 1;
          m_beats <= 0;
          for (int k = 0; k < UN; k++) m_acc[k] <= lane_of(bias, k);
        end
        1: if (x_valid) begin
          for (int k = 0; k < UN; k++) begin
            m_acc[k] <= m_acc[k] + fx_mul(x_data, w_tab[m_beats][k]);
            if (m_beats == VL - 1)
              m_out[k*DW +: DW] <= sat24(m_acc[k] + fx_mul(x_data, w_tab[m_beats][k]));
          end
          m_beats <= m_beats + 1;
          if (m_beats == VL - 1) begin
            m_phase     <= 2;
            m_data_zero <= 1'b0;
          end
        end
        2: if (out_ready) m_phase <= 0;
        default: m_phase <= 0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t act=%h exp=%h", name, $time, act, exp);
    end
  endtask

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", PW'(busy), PW'(m_phase != 0));
      chk("x_ready", PW'(x_ready), PW'(m_phase == 1));
      chk("out_valid", PW'(out_valid), PW'(m_phase == 2));
      chk("addr", PW'(addr), (m_phase == 1) ? PW'(m_beats) : '0);
      if (m_phase == 2) chk("out_data", out_data, m_out);
      else if (m_data_zero) chk("out_data_rst", out_data, '0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tabs(input logic [PW-1:0] wrow, input logic [DW-1:0] xv);
    for (int r = 0; r < VL; r++) begin
      x_tab[r] = xv;
      for (int k = 0; k < UN; k++) w_tab[r][k] = wrow[k*DW +: DW];
    end
  endtask

  task automatic junk_bias();
    for (int k = 0; k < UN; k++) bias[k*DW +: DW] = DW'($urandom);
  endtask

  task automatic start_job(input logic [PW-1:0] b);
    x_valid = 1'b1;
    x_data  = DW'($urandom);
    start   = 1'b1;
    bias    = b;
    tick();
    start   = 1'b0;
    junk_bias();
  endtask

  task automatic feed(input int stall, input int nbeats);
    int   idx;
    int   guard;
    logic hs;
    idx   = 0;
    guard = 0;
    while (idx < nbeats && guard < 4000) begin
      x_valid = ($urandom_range(0, 99) >= stall);
      x_data  = x_valid ? x_tab[idx] : DW'($urandom);
      @(negedge clk);
      hs = x_valid && x_ready;
      tick();
      if (hs) idx++;
      guard++;
    end
    x_valid = 1'b0;
    chk("beats_fed", PW'(idx), PW'(nbeats));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("done_latency", PW'(n), '0);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic chk_lanes(input string name, input logic [PW-1:0] exp);
    chk({name, "_model"}, m_out, exp);
    chk(name, out_data, exp);
  endtask

  localparam logic [PW-1:0] W_ONE   = {UN{24'h010000}};
  localparam logic [PW-1:0] W_MIX   = {24'hFF0000, 24'hFF0000, 24'h010000, 24'h010000, 24'h010000};
  localparam logic [PW-1:0] R_9C00  = {UN{24'h009C00}};
  localparam logic [PW-1:0] R_SAT   = {24'h800000, 24'h800000, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF};
  localparam logic [PW-1:0] R_NEG   = {UN{24'hFFFF64}};
  localparam logic [PW-1:0] B_LANE0 = {96'h0, 24'h7FFFF0};

  initial begin
    logic [PW-1:0] hold_data;
    start = 1'b0; x_valid = 1'b0; x_data = '0; out_ready = 1'b0; bias = '0;
    set_tabs(W_ONE, 24'h000100);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_addr", PW'(addr), '0);
    chk("rst_x_ready", PW'(x_ready), '0);
    chk("rst_busy", PW'(busy), '0);
    chk("rst_out_valid", PW'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk_en = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Unity weights, tiny input, no stalls
    start_job('0); feed(0, VL); wait_done();
    chk_lanes("unity", R_9C00);
    accept();

    // Saturation both ways
    set_tabs(W_MIX, 24'h010000);
    start_job(B_LANE0); feed(0, VL); wait_done();
    chk_lanes("saturate", R_SAT);
    accept();

    // Same as first job with ~40% stalls
    set_tabs(W_ONE, 24'h000100);
    start_job('0); feed(40, VL); wait_done();
    chk_lanes("stalled", R_9C00);

    // Hold result under backpressure with an ignored start
    hold_data = out_data;
    for (int i = 0; i < 10; i++) begin
      start = (i == 5);
      tick();
      chk("hold_data", out_data, hold_data);
      chk("hold_busy", PW'(busy), PW'(1));
    end
    start = 1'b0;
    accept();
    chk("release_valid", PW'(out_valid), '0);
    chk("release_busy", PW'(busy), '0);
    tick();

    // Reset after 80 beats, then a fresh job
    start_job('0); feed(0, 80);
    rst_n = 1'b0;
    #1;
    chk("midrst_addr", PW'(addr), '0);
    chk("midrst_x_ready", PW'(x_ready), '0);
    chk("midrst_busy", PW'(busy), '0);
    chk("midrst_out_valid", PW'(out_valid), '0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    start_job('0); feed(0, VL); wait_done();
    chk_lanes("after_reset", R_9C00);
    accept();

    // Negative LSB input: floor keeps -1 per beat
    set_tabs(W_ONE, 24'hFFFFFF);
    start_job('0); feed(0, VL); wait_done();
    chk_lanes("neg_lsb", R_NEG);
    accept();

    // Random jobs within +/-8.0 operands, random bias, stalls and backpressure
    for (int j = 0; j < 6; j++) begin
      logic [PW-1:0] b;
      for (int r = 0; r < VL; r++) begin
        int v;
        v = int'($urandom_range(0, 1048575)) - 524288;
        x_tab[r] = v[DW-1:0];
        for (int k = 0; k < UN; k++) begin
          v = int'($urandom_range(0, 1048575)) - 524288;
          if (j < 3) v = v >>> 4;
          w_tab[r][k] = v[DW-1:0];
        end
      end
      for (int k = 0; k < UN; k++) b[k*DW +: DW] = DW'($urandom);
      start_job(b); feed($urandom_range(0, 60), VL); wait_done();
      repeat ($urandom_range(0, 5)) tick();
      accept();
      repeat ($urandom_range(0, 3)) tick();
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog t=%0t act=running exp=finished", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
